// File: rtl/vita49_pkg.sv
// Shared definitions for the VITA49 IF Data packet framer: FSM state encoding,
// header field codes and bit positions, and the payload length clamp.
// Build option: VITA49_FRAMER_TRAILER_EN adds a trailer word after the payload.
package vita49_pkg;

  // The state code is exported on status[3:0], so the encoding is fixed.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR  = 4'd1,
    ST_SID  = 4'd2,
    ST_TSI  = 4'd3,
    ST_TSFH = 4'd4,
    ST_TSFL = 4'd5,
    ST_PAY  = 4'd6
`ifdef VITA49_FRAMER_TRAILER_EN
    ,
    ST_TRL  = 4'd7
`endif
  } state_e;

`ifdef VITA49_FRAMER_TRAILER_EN
  localparam bit TRAILER_EN = 1'b1;
`else
  localparam bit TRAILER_EN = 1'b0;
`endif

  // IF Data packet with Stream ID; UTC integer and real-time fractional stamps.
  localparam logic [3:0]  PKT_TYPE_IF_SID = 4'b0001;
  localparam logic [1:0]  TSI_CODE        = 2'b01;
  localparam logic [1:0]  TSF_CODE        = 2'b01;

  // Header, stream ID, TSI, TSF hi, TSF lo.
  localparam logic [15:0] HDR_WORDS = 16'd5;

  // Header field positions.
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_T_BIT    = 26;
  localparam int HDR_TSI_LSB  = 22;
  localparam int HDR_TSF_LSB  = 20;
  localparam int HDR_CNT_LSB  = 16;

  // A zero length still produces one payload word; oversize requests are capped.
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] max_len);
    if (len == 16'd0)
      return 16'd1;
    else if (len > max_len)
      return max_len;
    return len;
  endfunction

endpackage

// File: rtl/vita49_pkt_framer_if.sv
// 32-bit AXI-Stream bundle used for both the sample input and the packet output.
interface vita49_pkt_framer_if;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic        TLAST;
  logic        TVALID;
  logic        TREADY;

  modport master (output TDATA, TSTRB, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TSTRB, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/vita49_hdr_gen.sv
// Combinational generator for the five header-phase words of a packet.
// Returns zero outside the header states.
module vita49_hdr_gen
  import vita49_pkg::*;
(
  input  state_e      state,
  input  logic [3:0]  pkt_cnt,
  input  logic [15:0] len_l,
  input  logic        trl_en,
  input  logic [31:0] sid,
  input  logic [31:0] ts_int,
  input  logic [63:0] ts_frac,
  output logic [31:0] word
);

  logic [31:0] hdr;

  // Assemble the header word; packet size counts every 32-bit word sent.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hdr                      = '0;
    hdr[HDR_TYPE_LSB +: 4]   = PKT_TYPE_IF_SID;
    hdr[HDR_T_BIT]           = trl_en;
    hdr[HDR_TSI_LSB +: 2]    = TSI_CODE;
    hdr[HDR_TSF_LSB +: 2]    = TSF_CODE;
    hdr[HDR_CNT_LSB +: 4]    = pkt_cnt;
    hdr[15:0]                = HDR_WORDS + len_l + {15'd0, trl_en};
  end

  // Select the word for the current header state.
  always_comb begin
    word = '0;
    case (state)
      ST_HDR:  word = hdr;
      ST_SID:  word = sid;
      ST_TSI:  word = ts_int;
      ST_TSFH: word = ts_frac[63:32];
      ST_TSFL: word = ts_frac[31:0];
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/vita49_pkt_framer.sv
// VITA49 IF Data packet framer. Wraps a gated 32-bit sample stream into
// length-framed packets: header, stream ID, TSI, TSF hi, TSF lo, payload.
// Build option: define VITA49_FRAMER_TRAILER_EN to append a trailer word
// carrying the count of starved payload cycles.
module vita49_pkt_framer
  import vita49_pkg::*;
#(
  parameter int          C_AXIS_TDATA_NUM_BYTES = 4,
  parameter logic [15:0] C_MAX_PAYLOAD          = 16'd8192
) (
  input  logic                       AXIS_ACLK,
  input  logic                       AXIS_ARESET,
  vita49_pkt_framer_if.slave         s_axis,
  vita49_pkt_framer_if.master        m_axis,
  input  logic                       en,
  input  logic [31:0]                stream_id,
  input  logic [15:0]                payload_len,
  input  logic [31:0]                tsi,
  input  logic [63:0]                tsf,
  output logic [31:0]                status
);

  if (C_AXIS_TDATA_NUM_BYTES != 4) begin : g_bad_width
    $error("vita49_pkt_framer supports only a 4-byte stream");
  end

  state_e      state;
  logic [31:0] tsi_q;
  logic [63:0] tsf_q;
  logic [31:0] ts_int;
  logic [63:0] ts_frac;
  logic [31:0] sid_l;
  logic [15:0] len_l;
  logic [15:0] pay_cnt;
  logic [27:0] pkt_cnt;
  logic        hdr_vld;
  logic [31:0] hdr_word;
  logic        pay_hs;
  logic        pay_last;
  logic        unused_in;

`ifdef VITA49_FRAMER_TRAILER_EN
  logic [15:0] stall_cnt;
`endif

  // Framing is length-based, so the input strobe and last are not used.
  assign unused_in = ^{s_axis.TSTRB, s_axis.TLAST};

  assign pay_hs   = (state == ST_PAY) && s_axis.TVALID && m_axis.TREADY;
  assign pay_last = (pay_cnt == len_l - 16'd1);

  // Register the timing-unit value once before it is latched into a packet.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      tsi_q <= '0;
      tsf_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of block order.
      tsi_q <= tsi;
      tsf_q <= tsf;
    end
  end

  // Packet FSM: latches per-packet context at start, walks the header words,
  // counts payload handshakes and closes the packet on the last word.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state     <= ST_IDLE;
      ts_int    <= '0;
      ts_frac   <= '0;
      sid_l     <= '0;
      len_l     <= 16'd1;
      pay_cnt   <= '0;
      pkt_cnt   <= '0;
      hdr_vld   <= 1'b0;
`ifdef VITA49_FRAMER_TRAILER_EN
      stall_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && s_axis.TVALID) begin
            state     <= ST_HDR;
            ts_int    <= tsi_q;
            ts_frac   <= tsf_q;
            sid_l     <= stream_id;
            len_l     <= clamp_len(payload_len, C_MAX_PAYLOAD);
            pay_cnt   <= '0;
            hdr_vld   <= 1'b1;
`ifdef VITA49_FRAMER_TRAILER_EN
            stall_cnt <= '0;
`endif
          end
        end
        ST_HDR:  if (m_axis.TREADY) state <= ST_SID;
        ST_SID:  if (m_axis.TREADY) state <= ST_TSI;
        ST_TSI:  if (m_axis.TREADY) state <= ST_TSFH;
        ST_TSFH: if (m_axis.TREADY) state <= ST_TSFL;
        ST_TSFL: begin
          if (m_axis.TREADY) begin
            state   <= ST_PAY;
            hdr_vld <= 1'b0;
          end
        end
        ST_PAY: begin
`ifdef VITA49_FRAMER_TRAILER_EN
          if (!s_axis.TVALID && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
`endif
          if (pay_hs) begin
            pay_cnt <= pay_cnt + 16'd1;
            if (pay_last) begin
`ifdef VITA49_FRAMER_TRAILER_EN
              state   <= ST_TRL;
              hdr_vld <= 1'b1;
`else
              state   <= ST_IDLE;
              pkt_cnt <= pkt_cnt + 28'd1;
`endif
            end
          end
        end
`ifdef VITA49_FRAMER_TRAILER_EN
        ST_TRL: begin
          if (m_axis.TREADY) begin
            state   <= ST_IDLE;
            hdr_vld <= 1'b0;
            pkt_cnt <= pkt_cnt + 28'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  vita49_hdr_gen u_hdr_gen (
    .state   (state),
    .pkt_cnt (pkt_cnt[3:0]),
    .len_l   (len_l),
    .trl_en  (TRAILER_EN),
    .sid     (sid_l),
    .ts_int  (ts_int),
    .ts_frac (ts_frac),
    .word    (hdr_word)
  );

  // Output steering: header words from registers, payload passed straight through.
  always_comb begin
    m_axis.TDATA  = hdr_word;
    m_axis.TVALID = hdr_vld;
    m_axis.TLAST  = 1'b0;
    s_axis.TREADY = 1'b0;
    if (state == ST_PAY) begin
      m_axis.TDATA  = s_axis.TDATA;
      m_axis.TVALID = s_axis.TVALID;
      s_axis.TREADY = m_axis.TREADY;
`ifndef VITA49_FRAMER_TRAILER_EN
      m_axis.TLAST  = pay_last;
`endif
    end
`ifdef VITA49_FRAMER_TRAILER_EN
    if (state == ST_TRL) begin
      m_axis.TDATA = {16'h0000, stall_cnt};
      m_axis.TLAST = 1'b1;
    end
`endif
  end

  assign m_axis.TSTRB = 4'hF;
  assign status       = {pkt_cnt, 4'(state)};

endmodule

// File: tb/tb_vita49_pkt_framer.sv
// Directed bench for vita49_pkt_framer; builds with or without
// VITA49_FRAMER_TRAILER_EN and adjusts its expected packets accordingly.
`timescale 1ns/1ps
module tb_vita49_pkt_framer;

`ifdef VITA49_FRAMER_TRAILER_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESET;
  logic        en;
  logic [31:0] stream_id;
  logic [15:0] payload_len;
  logic [31:0] tsi;
  logic [63:0] tsf;
  logic [31:0] status;

  vita49_pkt_framer_if s_axis ();
  vita49_pkt_framer_if m_axis ();

  vita49_pkt_framer #(
    .C_AXIS_TDATA_NUM_BYTES (4),
    .C_MAX_PAYLOAD          (16'd8192)
  ) dut (
    .AXIS_ACLK   (AXIS_ACLK),
    .AXIS_ARESET (AXIS_ARESET),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .en          (en),
    .stream_id   (stream_id),
    .payload_len (payload_len),
    .tsi         (tsi),
    .tsf         (tsf),
    .status      (status)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] src_q[$];
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  logic        s_acc = 1'b0;
  int          s_acc_cnt = 0;
  int          bad_rdy = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;
  logic        rdy_toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_hdr(input logic [3:0] cnt, input int len_l);
    logic [15:0] sz;
    sz = 16'(5 + len_l + int'(T));
    return {4'b0001, 1'b0, T, 2'b00, 2'b01, 2'b01, cnt, sz};
  endfunction

  // Queue the words one packet should produce; len is the clamped length.
  task automatic expect_pkt(input logic [3:0] cnt, input int len, input logic [31:0] sid,
                            input logic [31:0] ti, input logic [63:0] tf,
                            input logic [31:0] first, input logic [15:0] stall);
    exp_q.push_back({1'b0, exp_hdr(cnt, len)});
    exp_q.push_back({1'b0, sid});
    exp_q.push_back({1'b0, ti});
    exp_q.push_back({1'b0, tf[63:32]});
    exp_q.push_back({1'b0, tf[31:0]});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(!T && i == len - 1), first + 32'(i)});
    if (T) exp_q.push_back({1'b1, 16'h0000, stall});
  endtask

  task automatic push_src(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + 32'(i));
  endtask

  // Wait (bounded) for the expected words, then compare them in order.
  task automatic drain(input string tag, input int budget);
    int n;
    n = exp_q.size();
    for (int i = 0; i < budget && out_q.size() < n; i++) @(negedge AXIS_ACLK);
    check({tag, "_nwords"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (out_q.size() > 0) check($sformatf("%s_w%0d", tag, i), 64'(out_q.pop_front()), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  // Source and sink driver: advance the sample queue after each accepted word.
  always @(posedge AXIS_ACLK) begin
    #1;
    if (s_acc && src_q.size() > 0) void'(src_q.pop_front());
    s_axis.TVALID = (src_q.size() > 0);
    s_axis.TDATA  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    m_axis.TREADY = rdy_toggle ? ~m_axis.TREADY : 1'b1;
  end

  // Monitor on the falling edge: capture output words, watch stalls and sample reads.
  always @(negedge AXIS_ACLK) begin
    if (!AXIS_ARESET) begin
      if (hold_pend) begin
        check("hold_data", 64'(m_axis.TDATA), 64'(hold_data));
        check("hold_valid", 64'(m_axis.TVALID), 64'd1);
      end
      hold_pend = m_axis.TVALID && !m_axis.TREADY;
      hold_data = m_axis.TDATA;
      if (m_axis.TVALID && m_axis.TREADY) out_q.push_back({m_axis.TLAST, m_axis.TDATA});
      if (s_axis.TREADY && status[3:0] != 4'd6) bad_rdy++;
      if (s_axis.TVALID && s_axis.TREADY) s_acc_cnt++;
      s_acc = s_axis.TVALID && s_axis.TREADY;
    end else begin
      hold_pend = 1'b0;
      s_acc     = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int any_last;

    AXIS_ARESET   = 1'b1;
    en            = 1'b0;
    stream_id     = 32'hCAFE_0001;
    payload_len   = 16'd4;
    tsi           = 32'h10;
    tsf           = 64'h5;
    s_axis.TDATA  = '0;
    s_axis.TSTRB  = 4'hF;
    s_axis.TLAST  = 1'b0;
    s_axis.TVALID = 1'b0;
    m_axis.TREADY = 1'b1;

    // Reset state.
    repeat (3) @(posedge AXIS_ACLK);
    #2;
    check("rst_m_tvalid", 64'(m_axis.TVALID), 64'd0);
    check("rst_m_tlast", 64'(m_axis.TLAST), 64'd0);
    check("rst_s_tready", 64'(s_axis.TREADY), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    AXIS_ARESET = 1'b0;
    @(posedge AXIS_ACLK);
    #2;
    en = 1'b1;

    // Basic packet, len=4, sink always ready.
    push_src(32'hA0, 4);
    expect_pkt(4'd0, 4, 32'hCAFE_0001, 32'h10, 64'h5, 32'hA0, 16'd0);
    drain("t1", 100);
    @(negedge AXIS_ACLK);
    check("t1_status", 64'(status), 64'h10);

    // Sink ready toggling: header words held while stalled.
    rdy_toggle = 1'b1;
    push_src(32'hB0, 4);
    expect_pkt(4'd1, 4, 32'hCAFE_0001, 32'h10, 64'h5, 32'hB0, 16'd0);
    drain("t2", 200);
    rdy_toggle = 1'b0;
    repeat (2) @(negedge AXIS_ACLK);
    check("t2_rdy_outside_pay", 64'(bad_rdy), 64'd0);
    check("t2_status", 64'(status), 64'h20);

    // 17 back-to-back packets from reset: header count wraps 15 -> 0.
    AXIS_ARESET = 1'b1;
    repeat (2) @(posedge AXIS_ACLK);
    #2;
    src_q.delete();
    out_q.delete();
    AXIS_ARESET = 1'b0;
    payload_len = 16'd2;
    push_src(32'h100, 34);
    for (int k = 0; k < 17; k++)
      expect_pkt(4'(k % 16), 2, 32'hCAFE_0001, 32'h10, 64'h5, 32'h100 + 32'(2 * k), 16'd0);
    drain("t3", 800);
    @(negedge AXIS_ACLK);
    check("t3_status", 64'(status), 64'h110);

    // Zero length becomes one word; new timestamp taken at packet start.
    tsi         = 32'h20;
    tsf         = 64'h0000_0001_0000_0007;
    payload_len = 16'd0;
    repeat (3) @(posedge AXIS_ACLK);
    #2;
    push_src(32'h200, 1);
    expect_pkt(4'd1, 1, 32'hCAFE_0001, 32'h20, 64'h0000_0001_0000_0007, 32'h200, 16'd0);
    drain("t4", 100);

    // Drop en after the second payload word of len=8; context changes ignored.
    payload_len = 16'd8;
    base        = s_acc_cnt;
    push_src(32'hC0, 8);
    push_src(32'hD0, 2);
    expect_pkt(4'd2, 8, 32'hCAFE_0001, 32'h20, 64'h0000_0001_0000_0007, 32'hC0, 16'd0);
    for (int i = 0; i < 200 && s_acc_cnt < base + 2; i++) @(posedge AXIS_ACLK);
    en          = 1'b0;
    payload_len = 16'd3;
    stream_id   = 32'h1234_5678;
    drain("t5", 200);
    repeat (20) @(negedge AXIS_ACLK);
    check("t5_no_new_words", 64'(out_q.size()), 64'd0);
    check("t5_src_left", 64'(src_q.size()), 64'd2);
    check("t5_status", 64'(status), 64'h130);

    // Reset while starved in PAY: abandon the packet, no TLAST.
    src_q.delete();
    repeat (2) @(posedge AXIS_ACLK);
    #2;
    stream_id   = 32'hCAFE_0001;
    payload_len = 16'd4;
    en          = 1'b1;
    push_src(32'hE0, 1);
    for (int i = 0; i < 100 && out_q.size() < 6; i++) @(posedge AXIS_ACLK);
    repeat (3) @(posedge AXIS_ACLK);
    #2;
    AXIS_ARESET = 1'b1;
    #1;
    check("t6_m_tvalid", 64'(m_axis.TVALID), 64'd0);
    check("t6_m_tlast", 64'(m_axis.TLAST), 64'd0);
    check("t6_status", 64'(status), 64'd0);
    check("t6_partial_words", 64'(out_q.size()), 64'd6);
    any_last = 0;
    foreach (out_q[i]) if (out_q[i][32]) any_last++;
    check("t6_no_tlast", 64'(any_last), 64'd0);
    repeat (2) @(posedge AXIS_ACLK);
    #2;
    src_q.delete();
    out_q.delete();
    AXIS_ARESET = 1'b0;
    payload_len = 16'd2;
    push_src(32'hF0, 2);
    expect_pkt(4'd0, 2, 32'hCAFE_0001, 32'h20, 64'h0000_0001_0000_0007, 32'hF0, 16'd0);
    drain("t6_fresh", 100);

`ifdef VITA49_FRAMER_TRAILER_EN
    // Three starved payload cycles reported in the trailer.
    payload_len = 16'd2;
    base        = s_acc_cnt;
    push_src(32'h300, 1);
    for (int i = 0; i < 100 && s_acc_cnt <= base; i++) @(posedge AXIS_ACLK);
    repeat (3) @(posedge AXIS_ACLK);
    push_src(32'h301, 1);
    expect_pkt(4'd1, 2, 32'hCAFE_0001, 32'h20, 64'h0000_0001_0000_0007, 32'h300, 16'd3);
    drain("t7_trl", 100);
`endif

    repeat (2) @(negedge AXIS_ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vita49_pkt_framer.md
Name: vita49_pkt_framer

Overview:
- Downstream neighbour of the VITA49 trigger gate.
- Consumes the gated 32-bit sample stream and emits VITA49 IF Data packets with Stream ID, framed on AXI-Stream.
- Each packet carries a header, stream ID, TSI, TSF hi and TSF lo, then a fixed number of payload words.
- The timestamp is the timing-unit value latched when the packet's first sample is presented; the output feeds the DMA/transport stage.

Parameters:
- C_AXIS_TDATA_NUM_BYTES, 4, stream width in bytes; only 4 is supported.
- C_MAX_PAYLOAD, 16'd8192, upper clamp on payload words per packet.

Ports:
- AXIS_ACLK  in  1  clock for all logic.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  32  sample word.
- S_AXIS_TSTRB  in  4  ignored.
- S_AXIS_TLAST  in  1  ignored; framing is length-based.
- S_AXIS_TVALID  in  1  sample valid.
- S_AXIS_TREADY  out  1  sample accepted.
- M_AXIS_TDATA  out  32  packet word.
- M_AXIS_TSTRB  out  4  always 4'hF.
- M_AXIS_TLAST  out  1  last word of packet.
- M_AXIS_TVALID  out  1  packet word valid.
- M_AXIS_TREADY  in  1  downstream ready.
- en  in  1  framing enable.
- stream_id  in  32  Stream ID word.
- payload_len  in  16  payload words per packet.
- tsi  in  32  timing-unit integer seconds.
- tsf  in  64  timing-unit fractional seconds.
- status  out  32  [31:4] packets sent (wraps), [3:0] state code.

Behaviour:
- Reset: every flop is cleared asynchronously on AXIS_ARESET=1. Reset values: state=IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, packet count=0, status=0.
- Reset mid-packet: the partial packet is abandoned and no TLAST is emitted.
- Timestamp path: tsi and tsf are registered once (tsi_q, tsf_q).
- State machine: IDLE, HDR, SID, TSI, TSFH, TSFL, PAY, TRL (TRL exists only with the optional feature).
- IDLE -> HDR when en=1 and S_AXIS_TVALID=1. On that edge the block latches:
  - tsi_q and tsf_q into the packet timestamp;
  - stream_id;
  - len_l = payload_len, clamped: 0 becomes 1, and values above C_MAX_PAYLOAD become C_MAX_PAYLOAD.
  - The sample is not consumed.
- HDR, SID, TSI, TSFH, TSFL:
  - M_AXIS_TVALID=1 and S_AXIS_TREADY=0.
  - Each state advances only on M_AXIS_TREADY=1.
  - M_AXIS_TDATA is held stable while stalled.
- Header word layout:
  - [31:28]=4'b0001.
  - [27]=0.
  - [26]=T (trailer present).
  - [25:24]=0.
  - [23:22]=2'b01.
  - [21:20]=2'b01.
  - [19:16]=packet count mod 16.
  - [15:0]=5+len_l+T.
- Other header-phase words:
  - SID: M_AXIS_TDATA = latched stream_id.
  - TSI: M_AXIS_TDATA = latched TSI.
  - TSFH: M_AXIS_TDATA = TSF[63:32].
  - TSFL: M_AXIS_TDATA = TSF[31:0].
- PAY: combinational pass-through.
  - M_AXIS_TDATA = S_AXIS_TDATA.
  - M_AXIS_TVALID = S_AXIS_TVALID.
  - S_AXIS_TREADY = M_AXIS_TREADY.
  - A 16-bit counter counts handshakes.
  - TLAST is asserted on the len_l-th word (without the optional feature).
  - After that word: go to IDLE, increment the packet count, and increment the 4-bit header count (wraps 15 -> 0).
- Input starvation in PAY (S_AXIS_TVALID=0, e.g. trigger closed): the packet stays open indefinitely; no padding and no timeout.
- en deasserted mid-packet: the current packet completes; IDLE then blocks new packets.
- Changes to payload_len or stream_id mid-packet have no effect until the next IDLE->HDR.
- Back-to-back packets: IDLE always costs one cycle between packets. The next packet's timestamp is the timing value at that IDLE edge.

Optional Feature:
- Macro: VITA49_FRAMER_TRAILER_EN.
- Defined:
  - T=1 and header size includes +1.
  - After the last payload word the block goes to TRL, which outputs one trailer word with TLAST: {16'h0, stall_cnt}.
  - stall_cnt is a 16-bit saturating count of PAY cycles with S_AXIS_TVALID=0, cleared at packet start.
  - The last payload word then carries TLAST=0.
- Undefined: T=0, no TRL state, no stall counter logic.

Decomposition:
- Package vita49_pkg:
  - state enum;
  - packet-type, TSI and TSF code constants;
  - header length constant (5);
  - header-field bit positions.
- One sub-module: vita49_hdr_gen, combinational. Inputs: state, count, len_l, T, stream ID, timestamp. Output: the 32-bit header-phase word.

Test Plan:
- len=4, tsi=0x10, tsf=0x5, M ready always, 4 samples 0xA0..0xA3 -> words 0x1050_0009, sid, 0x10, 0x0, 0x5, A0..A3; TLAST only on A3.
- Toggle M_AXIS_TREADY every other cycle during the header -> each header word held stable until accepted; no sample consumed before PAY.
- 17 back-to-back packets, len=2 -> header [19:16] sequence 0..15, then 0; status[31:4]=17.
- payload_len=0 -> header size 6, one payload word with TLAST.
- Drop en after the 2nd payload word of len=8 -> all 8 words plus TLAST sent, then no new header with input valid.
- Assert AXIS_ARESET during PAY -> M_AXIS_TVALID=0 and status=0 immediately; after release a fresh packet has count 0. With the optional feature: 3 starved cycles -> trailer 0x0000_0003 with TLAST.
